core_csr_trap_unit: RTL and testbench

CORE_CSR_TRAP_UNIT -- requirements
Module: core_csr_trap_unit

---
 rtl/core_csr_pkg.sv | 61 ++++++
 rtl/core_csr_regfile.sv | 123 ++++++++++++
 rtl/core_csr_trap_unit.sv | 135 +++++++++++++
 tb/tb_core_csr_trap_unit.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/core_csr_pkg.sv
// ============================================================================
// Module      : core_csr_pkg
// Description : Shared CSR addresses, trap causes, CSR op and FSM enums.
// Revision    : 1.0
// ============================================================================
`default_nettype none

package core_csr_pkg;

  localparam logic [11:0] C_CSR_MSTATUS  = 12'h300;
  localparam logic [11:0] C_CSR_MIE      = 12'h304;
  localparam logic [11:0] C_CSR_MTVEC    = 12'h305;
  localparam logic [11:0] C_CSR_MSCRATCH = 12'h340;
  localparam logic [11:0] C_CSR_MEPC     = 12'h341;
  localparam logic [11:0] C_CSR_MCAUSE   = 12'h342;
  localparam logic [11:0] C_CSR_MTVAL    = 12'h343;
  localparam logic [11:0] C_CSR_MIP      = 12'h344;

  localparam logic [31:0] C_CAUSE_IRQ_EXT = 32'h8000_000B;
  localparam logic [31:0] C_CAUSE_ILLEGAL = 32'd2;
  localparam logic [31:0] C_CAUSE_BREAK   = 32'd3;
  localparam logic [31:0] C_CAUSE_ECALL_M = 32'd11;

  localparam int C_MSTATUS_MIE  = 3;
  localparam int C_MSTATUS_MPIE = 7;
  localparam int C_MIX_MEI      = 11;

  typedef enum logic [1:0] {
    CSR_OP_NONE = 2'b00,
    CSR_OP_RW   = 2'b01,
    CSR_OP_RS   = 2'b10,
    CSR_OP_RC   = 2'b11
  } csr_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_TRAP = 2'd1,
    ST_RET  = 2'd2
  } trap_state_e;

  function automatic logic csr_is_mapped(input logic [11:0] addr);
    case (addr)
      C_CSR_MSTATUS, C_CSR_MIE, C_CSR_MTVEC, C_CSR_MSCRATCH,
      C_CSR_MEPC, C_CSR_MCAUSE, C_CSR_MTVAL, C_CSR_MIP: csr_is_mapped = 1'b1;
      default:                                          csr_is_mapped = 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] csr_apply(input csr_op_e op, input logic [31:0] old,
                                            input logic [31:0] wdata);
    case (op)
      CSR_OP_RW: csr_apply = wdata;
      CSR_OP_RS: csr_apply = old | wdata;
      CSR_OP_RC: csr_apply = old & ~wdata;
      default:   csr_apply = old;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/core_csr_regfile.sv
// ============================================================================
// Module      : core_csr_regfile
// Description : Machine-mode CSR storage and read mux; mie/mip live only when
//               CORE_CSR_TRAP_IRQ_EN is defined.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module core_csr_regfile
  import core_csr_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] i_addr,
  output logic [31:0] o_rdata,
  input  logic        i_wen,
  input  csr_op_e     i_op,
  input  logic [31:0] i_wdata,
  input  logic        i_trap_en,
  input  logic [31:0] i_trap_cause,
  input  logic [31:0] i_trap_epc,
  input  logic [31:0] i_trap_tval,
  input  logic        i_ret_en,
  input  logic        i_ext_irq,
  output logic        o_irq_pending,
  output logic [31:0] o_mtvec,
  output logic [31:0] o_mepc
);

  logic        r_mie;
  logic        r_mpie;
  logic [31:0] r_mtvec;
  logic [31:0] r_mscratch;
  logic [31:0] r_mepc;
  logic [31:0] r_mcause;
  logic [31:0] r_mtval;
  logic [31:0] w_mie_rd;
  logic [31:0] w_mip_rd;
  logic [31:0] w_new;

`ifdef CORE_CSR_TRAP_IRQ_EN
  logic r_meie;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_meie <= 1'b0;
    end else if (i_wen && !i_trap_en && i_addr == C_CSR_MIE) begin
      r_meie <= w_new[C_MIX_MEI];
    end
  end

  assign w_mie_rd      = {20'd0, r_meie, 11'd0};
  assign w_mip_rd      = {20'd0, i_ext_irq, 11'd0};
  assign o_irq_pending = r_mie & r_meie & i_ext_irq;
`else
  logic w_unused_irq;

  assign w_unused_irq  = i_ext_irq;
  assign w_mie_rd      = 32'd0;
  assign w_mip_rd      = 32'd0;
  assign o_irq_pending = 1'b0;
`endif

  always_comb begin
    o_rdata = 32'd0;
    case (i_addr)
      C_CSR_MSTATUS:  o_rdata = {24'd0, r_mpie, 3'd0, r_mie, 3'd0};
      C_CSR_MIE:      o_rdata = w_mie_rd;
      C_CSR_MTVEC:    o_rdata = r_mtvec;
      C_CSR_MSCRATCH: o_rdata = r_mscratch;
      C_CSR_MEPC:     o_rdata = r_mepc;
      C_CSR_MCAUSE:   o_rdata = r_mcause;
      C_CSR_MTVAL:    o_rdata = r_mtval;
      C_CSR_MIP:      o_rdata = w_mip_rd;
      default:        o_rdata = 32'd0;
    endcase
  end

  assign w_new   = csr_apply(i_op, o_rdata, i_wdata);
  assign o_mtvec = r_mtvec;
  assign o_mepc  = r_mepc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mie      <= 1'b0;
      r_mpie     <= 1'b0;
      r_mtvec    <= 32'd0;
      r_mscratch <= 32'd0;
      r_mepc     <= 32'd0;
      r_mcause   <= 32'd0;
      r_mtval    <= 32'd0;
    end else if (i_trap_en) begin
      r_mepc   <= {i_trap_epc[31:2], 2'b00};
      r_mcause <= i_trap_cause;
      r_mtval  <= i_trap_tval;
      r_mpie   <= r_mie;
      r_mie    <= 1'b0;
    end else begin
      if (i_ret_en) begin
        r_mie  <= r_mpie;
        r_mpie <= 1'b1;
      end
      // mip is never written here: the top flags any mip write as illegal
      if (i_wen) begin
        case (i_addr)
          C_CSR_MSTATUS: begin
            r_mie  <= w_new[C_MSTATUS_MIE];
            r_mpie <= w_new[C_MSTATUS_MPIE];
          end
          C_CSR_MTVEC:    r_mtvec    <= {w_new[31:2], 2'b00};
          C_CSR_MSCRATCH: r_mscratch <= w_new;
          C_CSR_MEPC:     r_mepc     <= {w_new[31:2], 2'b00};
          C_CSR_MCAUSE:   r_mcause   <= w_new;
          C_CSR_MTVAL:    r_mtval    <= w_new;
          default: ;
        endcase
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/core_csr_trap_unit.sv
// ============================================================================
// Module      : core_csr_trap_unit
// Description : Trap/return sequencer with cause priority and CSR op commit.
//               Interrupt entry enabled by CORE_CSR_TRAP_IRQ_EN.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module core_csr_trap_unit
  import core_csr_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_trap_valid,
  input  logic [31:0] i_trap_pc,
  input  logic [31:0] i_trap_instr,
  input  logic        i_trap_ecall,
  input  logic        i_trap_ebreak,
  input  logic        i_trap_mret,
  input  logic        i_trap_sret,
  input  logic        i_trap_illegal,
  input  logic        i_trap_csr_wen,
  input  logic [11:0] i_trap_csr_addr,
  input  logic [1:0]  i_trap_csr_op,
  input  logic [31:0] i_trap_csr_wdata,
  input  logic        i_trap_ext_irq,
  output logic        o_trap_busy,
  output logic        o_trap_redirect,
  output logic [31:0] o_trap_redirect_pc,
  output logic [31:0] o_trap_csr_rdata
);

  trap_state_e r_state;
  csr_op_e     w_op;
  logic        w_accept;
  logic        w_csr_access;
  logic        w_csr_write;
  logic        w_csr_bad;
  logic        w_irq;
  logic        w_take;
  logic [31:0] w_cause;
  logic [31:0] w_tval;
  logic        w_trap_en;
  logic        w_ret_en;
  logic        w_csr_wen;
  logic [31:0] w_mtvec;
  logic [31:0] w_mepc;

  assign w_op         = csr_op_e'(i_trap_csr_op);
  assign w_accept     = i_trap_valid && (r_state == ST_IDLE);
  assign w_csr_access = (w_op != CSR_OP_NONE);
  assign w_csr_write  = w_csr_access && i_trap_csr_wen;
  assign w_csr_bad    = w_csr_access && (!csr_is_mapped(i_trap_csr_addr) ||
                        (w_csr_write && i_trap_csr_addr == C_CSR_MIP));

  always_comb begin
    w_take  = 1'b1;
    w_cause = 32'd0;
    w_tval  = 32'd0;
    if (w_irq) begin
      w_cause = C_CAUSE_IRQ_EXT;
    end else if (i_trap_illegal || i_trap_sret || w_csr_bad) begin
      w_cause = C_CAUSE_ILLEGAL;
      w_tval  = i_trap_instr;
    end else if (i_trap_ebreak) begin
      w_cause = C_CAUSE_BREAK;
      w_tval  = i_trap_pc;
    end else if (i_trap_ecall) begin
      w_cause = C_CAUSE_ECALL_M;
    end else begin
      w_take  = 1'b0;
    end
  end

  // a trap suppresses both mret and any CSR write carried by the same request
  assign w_trap_en = w_accept && w_take;
  assign w_ret_en  = w_accept && !w_take && i_trap_mret;
  assign w_csr_wen = w_accept && !w_take && w_csr_write;

  core_csr_regfile u_regfile (
    .clk           (i_clk),
    .rst           (i_rst),
    .i_addr        (i_trap_csr_addr),
    .o_rdata       (o_trap_csr_rdata),
    .i_wen         (w_csr_wen),
    .i_op          (w_op),
    .i_wdata       (i_trap_csr_wdata),
    .i_trap_en     (w_trap_en),
    .i_trap_cause  (w_cause),
    .i_trap_epc    (i_trap_pc),
    .i_trap_tval   (w_tval),
    .i_ret_en      (w_ret_en),
    .i_ext_irq     (i_trap_ext_irq),
    .o_irq_pending (w_irq),
    .o_mtvec       (w_mtvec),
    .o_mepc        (w_mepc)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state            <= ST_IDLE;
      o_trap_busy        <= 1'b0;
      o_trap_redirect    <= 1'b0;
      o_trap_redirect_pc <= 32'd0;
    end else begin
      o_trap_redirect <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_trap_en) begin
            r_state            <= ST_TRAP;
            o_trap_busy        <= 1'b1;
            o_trap_redirect    <= 1'b1;
            o_trap_redirect_pc <= {w_mtvec[31:2], 2'b00};
          end else if (w_ret_en) begin
            r_state            <= ST_RET;
            o_trap_busy        <= 1'b1;
            o_trap_redirect    <= 1'b1;
            o_trap_redirect_pc <= w_mepc;
          end
        end
        ST_TRAP, ST_RET: begin
          r_state     <= ST_IDLE;
          o_trap_busy <= 1'b0;
        end
        default: begin
          r_state     <= ST_IDLE;
          o_trap_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_core_csr_trap_unit.sv
// ============================================================================
// Module      : tb_core_csr_trap_unit
// Description : Scoreboard bench for core_csr_trap_unit (expectations follow
//               CORE_CSR_TRAP_IRQ_EN when defined).
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_core_csr_trap_unit;

  localparam logic [5:0] F_ECALL  = 6'b000001;
  localparam logic [5:0] F_EBREAK = 6'b000010;
  localparam logic [5:0] F_MRET   = 6'b000100;
  localparam logic [5:0] F_SRET   = 6'b001000;
  localparam logic [5:0] F_ILL    = 6'b010000;
  localparam logic [5:0] F_WEN    = 6'b100000;

`ifdef CORE_CSR_TRAP_IRQ_EN
  localparam logic [31:0] C_EXP_MEI   = 32'h0000_0800;
  localparam logic [31:0] C_EXP_CAUSE = 32'h8000_000B;
`else
  localparam logic [31:0] C_EXP_MEI   = 32'h0000_0000;
  localparam logic [31:0] C_EXP_CAUSE = 32'd11;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        valid = 1'b0;
  logic [31:0] pc = '0;
  logic [31:0] instr = '0;
  logic        ecall = 1'b0, ebreak = 1'b0, mret = 1'b0, sret = 1'b0, illegal = 1'b0, wen = 1'b0;
  logic [11:0] addr = '0;
  logic [1:0]  op = '0;
  logic [31:0] wdata = '0;
  logic        irq = 1'b0;
  logic        busy, redirect;
  logic [31:0] redirect_pc, rdata;

  always #5 clk = ~clk;

  core_csr_trap_unit dut (
    .i_clk              (clk),
    .i_rst              (rst),
    .i_trap_valid       (valid),
    .i_trap_pc          (pc),
    .i_trap_instr       (instr),
    .i_trap_ecall       (ecall),
    .i_trap_ebreak      (ebreak),
    .i_trap_mret        (mret),
    .i_trap_sret        (sret),
    .i_trap_illegal     (illegal),
    .i_trap_csr_wen     (wen),
    .i_trap_csr_addr    (addr),
    .i_trap_csr_op      (op),
    .i_trap_csr_wdata   (wdata),
    .i_trap_ext_irq     (irq),
    .o_trap_busy        (busy),
    .o_trap_redirect    (redirect),
    .o_trap_redirect_pc (redirect_pc),
    .o_trap_csr_rdata   (rdata)
  );

  typedef struct {
    bit          is_redir;
    string       name;
    logic [31:0] val;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic expect_item(input bit is_redir, input string name, input logic [31:0] val);
    exp_t e;
    e.is_redir = is_redir;
    e.name     = name;
    e.val      = val;
    q.push_back(e);
  endtask

  task automatic pop(input bit is_redir, input logic [31:0] act);
    exp_t e;
    if (q.size() == 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL unexpected_%s: got 0x%08h expected none", is_redir ? "redirect" : "read", act);
    end else begin
      e = q.pop_front();
      if (e.is_redir != is_redir) begin
        n_cmp++;
        n_bad++;
        $display("FAIL %s: got %s event 0x%08h expected other kind", e.name,
                 is_redir ? "redirect" : "read", act);
      end else begin
        chk(e.name, act, e.val);
      end
    end
  endtask

  // monitor: an accepted CSR access shows its old value, a redirect its target
  always @(negedge clk) begin
    if (!rst) begin
      if (valid && !busy && op != 2'b00) pop(1'b0, rdata);
      if (redirect) begin
        chk("busy_during_redirect", {31'd0, busy}, 32'd1);
        pop(1'b1, redirect_pc);
      end
    end
  end

  task automatic drive(input logic [31:0] p, input logic [31:0] ins, input logic [5:0] fl,
                       input logic [11:0] a, input logic [1:0] o, input logic [31:0] wd);
    valid = 1'b1; pc = p; instr = ins;
    ecall = fl[0]; ebreak = fl[1]; mret = fl[2]; sret = fl[3]; illegal = fl[4]; wen = fl[5];
    addr = a; op = o; wdata = wd;
  endtask

  task automatic clear_req();
    drive('0, '0, '0, '0, 2'b00, '0);
    valid = 1'b0;
  endtask

  task automatic issue(input logic [31:0] p, input logic [31:0] ins, input logic [5:0] fl,
                       input logic [11:0] a, input logic [1:0] o, input logic [31:0] wd);
    @(posedge clk); #1 drive(p, ins, fl, a, o, wd);
    @(posedge clk); #1 clear_req();
  endtask

  task automatic csr_rd(input string name, input logic [11:0] a, input logic [31:0] exp);
    expect_item(1'b0, name, exp);
    issue('0, '0, '0, a, 2'b10, '0);
  endtask

  task automatic csr_wr(input string name, input logic [11:0] a, input logic [1:0] o,
                        input logic [31:0] wd, input logic [31:0] old);
    expect_item(1'b0, name, old);
    issue('0, '0, F_WEN, a, o, wd);
  endtask

  // trap or mret request; optional CSR op whose old value is also expected
  task automatic trap_req(input string name, input logic [31:0] p, input logic [31:0] ins,
                          input logic [5:0] fl, input logic [11:0] a, input logic [1:0] o,
                          input logic [31:0] old, input logic [31:0] target);
    if (o != 2'b00) expect_item(1'b0, {name, "_rdata"}, old);
    expect_item(1'b1, {name, "_redirect_pc"}, target);
    issue(p, ins, fl, a, o, 32'h55);
    chk({name, "_busy_trap"}, {31'd0, busy}, 32'd1);
    @(posedge clk); #1;
    chk({name, "_busy_after"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_redirect", {31'd0, redirect}, 32'd0);
    chk("rst_redirect_pc", redirect_pc, 32'd0);
    rst = 1'b0;
    csr_rd("rst_mstatus", 12'h300, 32'd0);
    csr_rd("rst_mie", 12'h304, 32'd0);
    csr_rd("rst_mtvec", 12'h305, 32'd0);
    csr_rd("rst_mscratch", 12'h340, 32'd0);
    csr_rd("rst_mepc", 12'h341, 32'd0);
    csr_rd("rst_mcause", 12'h342, 32'd0);
    csr_rd("rst_mtval", 12'h343, 32'd0);
    csr_rd("rst_mip", 12'h344, 32'd0);

    // ecall through mtvec=0x100
    csr_wr("mtvec_w100", 12'h305, 2'b01, 32'h100, 32'd0);
    csr_rd("mtvec_100", 12'h305, 32'h100);
    trap_req("ecall", 32'h2004, 32'h73, F_ECALL, '0, 2'b00, '0, 32'h100);
    csr_rd("ecall_mepc", 12'h341, 32'h2004);
    csr_rd("ecall_mcause", 12'h342, 32'd11);
    csr_rd("ecall_mtval", 12'h343, 32'd0);
    csr_rd("ecall_mstatus", 12'h300, 32'd0);

    // illegal with MIE=1 beforehand
    csr_wr("mstatus_set_mie", 12'h300, 2'b10, 32'h8, 32'd0);
    trap_req("illegal", 32'h40, 32'hFFFF_FFFF, F_ILL, '0, 2'b00, '0, 32'h100);
    csr_rd("ill_mcause", 12'h342, 32'd2);
    csr_rd("ill_mtval", 12'h343, 32'hFFFF_FFFF);
    csr_rd("ill_mepc", 12'h341, 32'h40);
    csr_rd("ill_mstatus", 12'h300, 32'h80);

    // mret to mepc=0x88 with MPIE=1
    csr_wr("mepc_w8b", 12'h341, 2'b01, 32'h8B, 32'h40);
    csr_rd("mepc_88", 12'h341, 32'h88);
    trap_req("mret", 32'h44, 32'h30200073, F_MRET, '0, 2'b00, '0, 32'h88);
    csr_rd("mret_mstatus", 12'h300, 32'h88);

    // csrrs on mtvec cannot set the forced-zero low bits
    csr_wr("mtvec_w200", 12'h305, 2'b01, 32'h200, 32'h100);
    csr_wr("mtvec_rs3", 12'h305, 2'b10, 32'h3, 32'h200);
    csr_rd("mtvec_200", 12'h305, 32'h200);

    trap_req("unmapped", 32'h300, 32'h7C029073, F_WEN, 12'h7C0, 2'b01, '0, 32'h200);
    csr_rd("unm_mcause", 12'h342, 32'd2);
    csr_rd("unm_mtval", 12'h343, 32'h7C029073);
    csr_rd("unm_mepc", 12'h341, 32'h300);
    csr_rd("unm_mstatus", 12'h300, 32'h80);

    trap_req("sret", 32'h504, 32'h10200073, F_SRET, '0, 2'b00, '0, 32'h200);
    csr_rd("sret_mcause", 12'h342, 32'd2);
    csr_rd("sret_mtval", 12'h343, 32'h10200073);

    trap_req("mip_write", 32'h508, 32'h34401073, F_WEN, 12'h344, 2'b01, '0, 32'h200);
    csr_rd("mipw_mcause", 12'h342, 32'd2);

    trap_req("ebreak", 32'h50C, 32'h00100073, F_EBREAK, '0, 2'b00, '0, 32'h200);
    csr_rd("ebreak_mcause", 12'h342, 32'd3);
    csr_rd("ebreak_mtval", 12'h343, 32'h50C);

    // trap beats a simultaneous CSR write
    trap_req("ecall_csrw", 32'h510, 32'h34029073, F_ECALL | F_WEN, 12'h340, 2'b01, '0, 32'h200);
    csr_rd("csrw_dropped", 12'h340, 32'd0);
    csr_rd("csrw_mcause", 12'h342, 32'd11);
    csr_wr("mscratch_rw", 12'h340, 2'b01, 32'hF0F0, 32'd0);
    csr_wr("mscratch_rc", 12'h340, 2'b11, 32'h00F0, 32'hF0F0);
    csr_rd("mscratch_f000", 12'h340, 32'hF000);

    // mtvec write immediately followed by a trap
    expect_item(1'b0, "b2b_mtvec_old", 32'h200);
    expect_item(1'b1, "b2b_redirect_pc", 32'h400);
    @(posedge clk); #1 drive('0, '0, F_WEN, 12'h305, 2'b01, 32'h400);
    @(posedge clk); #1 drive(32'h600, 32'h73, F_ECALL, '0, 2'b00, '0);
    @(posedge clk); #1 clear_req();
    chk("b2b_busy", {31'd0, busy}, 32'd1);
    csr_rd("b2b_mepc", 12'h341, 32'h600);

    // external interrupt versus ecall
    csr_wr("mie_set", 12'h304, 2'b10, 32'h800, 32'd0);
    csr_rd("mie_rd", 12'h304, C_EXP_MEI);
    irq = 1'b1;
    csr_rd("mip_rd", 12'h344, C_EXP_MEI);
    csr_wr("mstatus_mie2", 12'h300, 2'b10, 32'h8, 32'd0);
    trap_req("irq_ecall", 32'h700, 32'h73, F_ECALL, '0, 2'b00, '0, 32'h400);
    irq = 1'b0;
    csr_rd("irq_mcause", 12'h342, C_EXP_CAUSE);
    csr_rd("irq_mtval", 12'h343, 32'd0);
    csr_rd("irq_mstatus", 12'h300, 32'h80);

    // second request during TRAP is ignored
    expect_item(1'b1, "busy_first_redirect", 32'h400);
    @(posedge clk); #1 drive(32'h800, 32'h73, F_ECALL, '0, 2'b00, '0);
    @(posedge clk); #1;
    chk("busy_hold", {31'd0, busy}, 32'd1);
    drive(32'h900, 32'h73, F_ECALL, '0, 2'b00, '0);
    @(posedge clk); #1 clear_req();
    chk("busy_released", {31'd0, busy}, 32'd0);
    csr_rd("busy_mepc", 12'h341, 32'h800);

    // reset during TRAP: no redirect, all CSRs cleared
    @(posedge clk); #1 drive(32'hA00, 32'h73, F_ECALL, '0, 2'b00, '0);
    @(posedge clk); #1 clear_req();
    rst = 1'b1;
    #1;
    chk("rstmid_redirect", {31'd0, redirect}, 32'd0);
    chk("rstmid_busy", {31'd0, busy}, 32'd0);
    chk("rstmid_redirect_pc", redirect_pc, 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    csr_rd("rstmid_mtvec", 12'h305, 32'd0);
    csr_rd("rstmid_mepc", 12'h341, 32'd0);
    csr_rd("rstmid_mcause", 12'h342, 32'd0);
    csr_rd("rstmid_mtval", 12'h343, 32'd0);
    csr_rd("rstmid_mstatus", 12'h300, 32'd0);
    csr_rd("rstmid_mscratch", 12'h340, 32'd0);

    repeat (4) @(posedge clk);
    #1;
    while (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      n_cmp++;
      n_bad++;
      $display("FAIL %s: got no event expected 0x%08h", e.name, e.val);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
